// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder
// Packs an incoming byte stream big-endian into 32-bit words and appends the
// SHA-256 padding (0x80 terminator, zero fill, 64-bit big-endian bit length).
// Words leave one at a time over a valid/ready handshake, tagged with their
// index in the 512-bit block and with first-block / final-word flags.
module sha256_msg_padder #(
    parameter int unsigned MAX_BYTES_W = 61
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_msg_first,
    output logic        out_msg_last,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        PAD80,
        ZERO,
        LEN_HI,
        LEN_LO
    } state_t;

    state_t                 state;
    state_t                 state_nx;

    logic [31:0]            word_buf;    // partially assembled word, unused bytes kept zero
    logic [1:0]             byte_pos;    // number of bytes currently held in word_buf
    logic [3:0]             next_idx;    // block index the next emitted word will carry
    logic [MAX_BYTES_W-1:0] byte_cnt;    // message length in bytes (saturating)
    logic                   first_blk;   // still inside the first block of the message

    logic                   can_load;    // output register is free or being emptied now
    logic                   accept;      // byte handshake this cycle
    logic                   load_en;
    logic                   load_last;
    logic [31:0]            load_data;
    logic [63:0]            bit_len;
    logic [31:0]            pad_word;
    logic [31:0]            full_word;

    // Derived datapath values feeding the word selection
    always_comb begin
        bit_len   = 64'({byte_cnt, 3'b000});
        pad_word  = word_buf | (32'h8000_0000 >> {byte_pos, 3'b000});
        full_word = {word_buf[31:8], in_byte};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = in_last ? PAD80 : ACCUM;
                end
            end
            ACCUM: begin
                if (accept && in_last) begin
                    state_nx = PAD80;
                end
            end
            PAD80: begin
                if (can_load) begin
                    state_nx = ZERO;
                end
            end
            // Zero words run until the next slot is index 14; a terminator that
            // landed at 14 or 15 therefore wraps through a whole extra block.
            ZERO: begin
                if (next_idx == 4'd14) begin
                    state_nx = LEN_HI;
                end
            end
            LEN_HI: begin
                if (can_load) begin
                    state_nx = LEN_LO;
                end
            end
            LEN_LO: begin
                if (can_load) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Output/control decode: byte acceptance and which word (if any) loads
    always_comb begin
        can_load  = !out_valid || out_ready;
        in_ready  = ((state == IDLE) || (state == ACCUM)) && can_load;
        accept    = in_valid && in_ready;
        load_en   = 1'b0;
        load_last = 1'b0;
        load_data = '0;
        case (state)
            IDLE, ACCUM: begin
                if (accept && (byte_pos == 2'd3)) begin
                    load_en   = 1'b1;
                    load_data = full_word;
                end
            end
            PAD80: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_data = pad_word;
                end
            end
            ZERO: begin
                if (can_load && (next_idx != 4'd14)) begin
                    load_en   = 1'b1;
                    load_data = '0;
                end
            end
            LEN_HI: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_data = bit_len[63:32];
                end
            end
            LEN_LO: begin
                if (can_load) begin
                    load_en   = 1'b1;
                    load_last = 1'b1;
                    load_data = bit_len[31:0];
                end
            end
            default: begin
                load_en = 1'b0;
            end
        endcase
    end

    // Byte packing buffer; cleared whenever its contents leave as a word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_buf <= '0;
            byte_pos <= '0;
        end else if (accept) begin
            if (byte_pos == 2'd3) begin
                word_buf <= '0;
                byte_pos <= '0;
            end else begin
                case (byte_pos)
                    2'd0:    word_buf[31:24] <= in_byte;
                    2'd1:    word_buf[23:16] <= in_byte;
                    default: word_buf[15:8]  <= in_byte;
                endcase
                byte_pos <= byte_pos + 2'd1;
            end
        end else if ((state == PAD80) && can_load) begin
            word_buf <= '0;
            byte_pos <= '0;
        end
    end

    // Saturating message byte counter, restarted by the first byte of a message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
        end else if (accept) begin
            if (state == IDLE) begin
                byte_cnt <= MAX_BYTES_W'(1);
            end else if (byte_cnt != '1) begin
                byte_cnt <= byte_cnt + MAX_BYTES_W'(1);
            end
        end
    end

    // Output word register: holds steady while the core stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_word      <= '0;
            out_valid     <= 1'b0;
            out_idx       <= '0;
            out_msg_first <= 1'b0;
            out_msg_last  <= 1'b0;
            next_idx      <= '0;
        end else if (load_en) begin
            out_word      <= load_data;
            out_valid     <= 1'b1;
            out_idx       <= next_idx;
            out_msg_first <= first_blk;
            out_msg_last  <= load_last;
            next_idx      <= next_idx + 4'd1;
        end else if (out_ready) begin
            out_valid     <= 1'b0;
        end
    end

    // First-block flag: set at message start, dropped once W15 of block 0 loads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_blk <= 1'b0;
        end else if (accept && (state == IDLE)) begin
            first_blk <= 1'b1;
        end else if (load_en && (next_idx == 4'd15)) begin
            first_blk <= 1'b0;
        end
    end

    // Busy from the first accepted byte until the final word is taken;
    // a new message starting in that same cycle keeps it high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
        end else if (accept && (state == IDLE)) begin
            busy <= 1'b1;
        end else if (out_valid && out_ready && out_msg_last) begin
            busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder
// Self-checking bench: a reference padder fills a scoreboard of expected
// words; a monitor pops and compares every word the core accepts.
module tb_sha256_msg_padder;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic [31:0] w;
        logic [3:0]  idx;
        logic        first;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_word;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_idx;
    logic        out_msg_first;
    logic        out_msg_last;
    logic        busy;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    sha256_msg_padder #(.MAX_BYTES_W(61)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_ready      (in_ready),
        .out_word      (out_word),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_idx       (out_idx),
        .out_msg_first (out_msg_first),
        .out_msg_last  (out_msg_last),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Monitor: 1ns before the rising edge, pop and compare each accepted word
    always begin
        @(negedge clk);
        #4;
        if (rst_n && out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_word: got word=%h idx=%0d, required no word", out_word, out_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_word, out_idx, out_msg_first, out_msg_last} !== {e.w, e.idx, e.first, e.last}) begin
                    bad++;
                    $display("FAIL word: got %h idx=%0d first=%b last=%b, required %h idx=%0d first=%b last=%b",
                             out_word, out_idx, out_msg_first, out_msg_last, e.w, e.idx, e.first, e.last);
                end
            end
        end
    end

    function automatic bq_t ramp(input int n, input int base);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'(base + i));
        return q;
    endfunction

    // Reference FIPS 180-4 padding: push every expected word of the message
    task automatic push_expected(input bq_t msg);
        bq_t         p;
        logic [63:0] bl;
        exp_t        e;
        int          nw;
        p  = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nw = p.size() / 4;
        for (int w = 0; w < nw; w++) begin
            e.w     = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.idx   = 4'(w % 16);
            e.first = (w < 16);
            e.last  = (w == nw - 1);
            sb.push_back(e);
        end
    endtask

    // Drive bytes one per accepted handshake; stuck counts bytes never taken
    task automatic drive_msg(input bq_t msg, input bit with_last, output int stuck);
        bit ok;
        stuck = 0;
        for (int i = 0; i < msg.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = with_last && (i == msg.size() - 1);
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                #4;
                if (in_ready) begin
                    ok = 1'b1;
                    @(posedge clk);
                    break;
                end
                @(negedge clk);
            end
            if (!ok) stuck++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain(output int left);
        for (int c = 0; c < 400 && sb.size() != 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        left = sb.size();
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, out_word, out_idx, out_msg_first, out_msg_last, busy} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got valid=%b word=%h idx=%0d first=%b last=%b busy=%b, required all 0",
                     out_valid, out_word, out_idx, out_msg_first, out_msg_last, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready: got in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_abc;
        bq_t m;
        int  st, left;
        m = '{8'h61, 8'h62, 8'h63};
        push_expected(m);
        drive_msg(m, 1'b1, st);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abc_busy_during: got %b, required 1", busy);
        end
        drain(left);
        total++;
        if ({st, left} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL abc_drain: got stuck=%0d left=%0d, required 0 0", st, left);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL abc_busy_after: got %b, required 0", busy);
        end
    endtask

    task automatic test_boundary(input int n);
        bq_t m;
        int  st, left;
        m = ramp(n, 0);
        push_expected(m);
        drive_msg(m, 1'b1, st);
        drain(left);
        total++;
        if ({st, left} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL boundary_%0d: got stuck=%0d left=%0d, required 0 0", n, st, left);
        end
    endtask

    task automatic test_backpressure;
        bq_t         m;
        int          st, left;
        logic [31:0] hw;
        logic [3:0]  hi;
        bit          seen;
        m = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
        push_expected(m);
        fork
            drive_msg(m, 1'b1, st);
            begin
                seen = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                total++;
                if (seen !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_word_seen: got no out_valid in 50 cycles, required one");
                end
                out_ready = 1'b0;
                hw = out_word;
                hi = out_idx;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    #1;
                    total++;
                    if ({out_valid, out_word, out_idx, in_ready} !== {1'b1, hw, hi, 1'b0}) begin
                        bad++;
                        $display("FAIL bp_hold: got valid=%b word=%h idx=%0d in_ready=%b, required 1 %h %0d 0",
                                 out_valid, out_word, out_idx, in_ready, hw, hi);
                    end
                end
                out_ready = 1'b1;
            end
        join
        drain(left);
        total++;
        if ({st, left} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL bp_drain: got stuck=%0d left=%0d, required 0 0", st, left);
        end
    endtask

    task automatic test_reset_mid;
        bq_t  m, part;
        int   st;
        exp_t e;
        m = ramp(20, 8'h10);
        for (int i = 0; i < 10; i++) part.push_back(m[i]);
        for (int w = 0; w < 2; w++) begin
            e.w = {m[4*w], m[4*w+1], m[4*w+2], m[4*w+3]};
            e.idx = 4'(w); e.first = 1'b1; e.last = 1'b0;
            sb.push_back(e);
        end
        drive_msg(part, 1'b0, st);
        repeat (3) @(negedge clk);
        total++;
        if ({st, sb.size()} !== {32'd0, 32'd0}) begin
            bad++;
            $display("FAIL partial_words: got stuck=%0d pending=%0d, required 0 0", st, sb.size());
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, out_word, out_idx, out_msg_first, out_msg_last, busy} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got valid=%b word=%h idx=%0d first=%b last=%b busy=%b, required all 0",
                     out_valid, out_word, out_idx, out_msg_first, out_msg_last, busy);
        end
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_abc();
    endtask

    task automatic test_back_to_back;
        bq_t a, b;
        int  st1, st2, left;
        a = '{8'h61, 8'h62, 8'h63};
        b = ramp(5, 8'hA0);
        push_expected(a);
        push_expected(b);
        drive_msg(a, 1'b1, st1);
        drive_msg(b, 1'b1, st2);
        drain(left);
        total++;
        if ({st1, st2, left} !== {32'd0, 32'd0, 32'd0}) begin
            bad++;
            $display("FAIL b2b_drain: got stuck=%0d/%0d left=%0d, required 0 0 0", st1, st2, left);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_boundary(55);
        test_boundary(56);
        test_boundary(64);
        test_boundary(1);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
